// File: rtl/ysyx_22050710_csr_ctrl_if.sv
// Request/response and CSR-file port bundle for the CSR sequencing controller.
// master: the execute stage plus the CSR file (drives i_*, observes o_*).
// slave:  the controller itself.
interface ysyx_22050710_csr_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 64
);
    localparam int unsigned PC_WIDTH = 64;

    // Request side
    logic                  i_valid;
    logic                  o_ready;
    logic [2:0]            i_op;
    logic [ADDR_WIDTH-1:0] i_csr_addr;
    logic [DATA_WIDTH-1:0] i_rs1_data;
    logic [4:0]            i_uimm;
    logic [PC_WIDTH-1:0]   i_pc;

    // CSR file read port
    logic [ADDR_WIDTH-1:0] o_csr_raddr;
    logic                  o_csr_ren;
    logic [DATA_WIDTH-1:0] i_csr_rdata;

    // CSR file write port
    logic [ADDR_WIDTH-1:0] o_csr_waddr;
    logic [DATA_WIDTH-1:0] o_csr_wdata;
    logic                  o_csr_wen;

    // Completion
    logic                  o_done;
    logic [DATA_WIDTH-1:0] o_rd_data;
    logic                  o_redirect;
    logic [PC_WIDTH-1:0]   o_nextpc;

    modport master (
        output i_valid, i_op, i_csr_addr, i_rs1_data, i_uimm, i_pc, i_csr_rdata,
        input  o_ready, o_csr_raddr, o_csr_ren, o_csr_waddr, o_csr_wdata, o_csr_wen,
        input  o_done, o_rd_data, o_redirect, o_nextpc
    );

    modport slave (
        input  i_valid, i_op, i_csr_addr, i_rs1_data, i_uimm, i_pc, i_csr_rdata,
        output o_ready, o_csr_raddr, o_csr_ren, o_csr_waddr, o_csr_wdata, o_csr_wen,
        output o_done, o_rd_data, o_redirect, o_nextpc
    );
endinterface

// File: rtl/ysyx_22050710_csr_ctrl.sv
// CSR sequencing controller: runs Zicsr read-modify-write ops, ECALL trap entry
// and MRET trap return as fixed multi-cycle sequences on the CSR file ports.
module ysyx_22050710_csr_ctrl #(
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned ECALL_CAUSE = 11
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    ysyx_22050710_csr_ctrl_if.slave bus
);
    localparam int unsigned PC_WIDTH = 64;

    localparam logic [ADDR_WIDTH-1:0] CSR_MSTATUS = ADDR_WIDTH'(12'h300);
    localparam logic [ADDR_WIDTH-1:0] CSR_MTVEC   = ADDR_WIDTH'(12'h305);
    localparam logic [ADDR_WIDTH-1:0] CSR_MEPC    = ADDR_WIDTH'(12'h341);
    localparam logic [ADDR_WIDTH-1:0] CSR_MCAUSE  = ADDR_WIDTH'(12'h342);

    localparam logic [2:0] OP_MRET  = 3'b000;
    localparam logic [2:0] OP_ECALL = 3'b100;

    // Low two op bits select the RMW flavour for both register and immediate forms.
    localparam logic [1:0] KIND_RW = 2'b01;
    localparam logic [1:0] KIND_RS = 2'b10;

    typedef enum logic [3:0] {
        IDLE,
        RD,
        WR,
        TRAP_EPC,
        TRAP_CAUSE,
        TRAP_STAT,
        TRAP_VEC,
        RET_STAT,
        RET_EPC,
        RESP
    } state_t;

    state_t                state;
    logic [1:0]            kind_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] operand_q;
    logic                  skip_q;
    logic [DATA_WIDTH-1:0] old_q;
    logic                  wen_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    logic [DATA_WIDTH-1:0] req_operand_c;
    logic                  req_skip_c;
    logic                  wen_c;
    logic [DATA_WIDTH-1:0] wdata_c;

    // MSTATUS on trap entry: MPIE <= MIE, MIE <= 0, MPP <= M.
    function automatic logic [DATA_WIDTH-1:0] mstatus_trap(input logic [DATA_WIDTH-1:0] s);
        logic [DATA_WIDTH-1:0] r;
        r         = s;
        r[7]      = s[3];
        r[3]      = 1'b0;
        r[12:11]  = 2'b11;
        return r;
    endfunction

    // MSTATUS on trap return: MIE <= MPIE, MPIE <= 1, MPP stays M (M-mode only core).
    function automatic logic [DATA_WIDTH-1:0] mstatus_ret(input logic [DATA_WIDTH-1:0] s);
        logic [DATA_WIDTH-1:0] r;
        r         = s;
        r[3]      = s[7];
        r[7]      = 1'b1;
        r[12:11]  = 2'b11;
        return r;
    endfunction

    // New CSR value for the write/set/clear flavours.
    function automatic logic [DATA_WIDTH-1:0] rmw_value(input logic [1:0] kind,
                                                        input logic [DATA_WIDTH-1:0] old,
                                                        input logic [DATA_WIDTH-1:0] opnd);
        logic [DATA_WIDTH-1:0] r;
        if (kind == KIND_RW) begin
            r = opnd;
        end else if (kind == KIND_RS) begin
            r = old | opnd;
        end else begin
            r = old & ~opnd;
        end
        return r;
    endfunction

    // Operand selection and rs1=x0 / zimm=0 write suppression for an incoming request.
    always_comb begin
        req_operand_c = bus.i_rs1_data;
        if (bus.i_op[2]) begin
            req_operand_c = DATA_WIDTH'(bus.i_uimm);
        end
        req_skip_c = bus.i_op[1] & (bus.i_uimm == 5'd0);
    end

    // Write port: a reset sampled this edge must keep the pending write from committing;
    // the MSTATUS updates are same-cycle read-modify-writes so their data follows the read port.
    always_comb begin
        wen_c   = wen_q & ~i_rst;
        wdata_c = '0;
        if (wen_c) begin
            if (state == TRAP_STAT) begin
                wdata_c = mstatus_trap(bus.i_csr_rdata);
            end else if (state == RET_STAT) begin
                wdata_c = mstatus_ret(bus.i_csr_rdata);
            end else begin
                wdata_c = wdata_q;
            end
        end
    end

    assign bus.o_csr_wen   = wen_c;
    assign bus.o_csr_wdata = wdata_c;

    // Sequencer: state, latched request and all registered port/response outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state           <= IDLE;
            kind_q          <= '0;
            addr_q          <= '0;
            operand_q       <= '0;
            skip_q          <= 1'b0;
            old_q           <= '0;
            wen_q           <= 1'b0;
            wdata_q         <= '0;
            bus.o_ready     <= 1'b1;
            bus.o_csr_ren   <= 1'b0;
            bus.o_csr_raddr <= '0;
            bus.o_csr_waddr <= '0;
            bus.o_done      <= 1'b0;
            bus.o_rd_data   <= '0;
            bus.o_redirect  <= 1'b0;
            bus.o_nextpc    <= '0;
        end else begin
            bus.o_csr_ren   <= 1'b0;
            bus.o_csr_raddr <= '0;
            wen_q           <= 1'b0;
            bus.o_csr_waddr <= '0;
            wdata_q         <= '0;
            bus.o_done      <= 1'b0;
            bus.o_rd_data   <= '0;
            bus.o_redirect  <= 1'b0;
            bus.o_nextpc    <= '0;

            case (state)
                IDLE: begin
                    if (bus.i_valid) begin
                        bus.o_ready <= 1'b0;
                        kind_q      <= bus.i_op[1:0];
                        addr_q      <= bus.i_csr_addr;
                        operand_q   <= req_operand_c;
                        skip_q      <= req_skip_c;
                        if (bus.i_op == OP_ECALL) begin
                            state           <= TRAP_EPC;
                            wen_q           <= 1'b1;
                            bus.o_csr_waddr <= CSR_MEPC;
                            wdata_q         <= DATA_WIDTH'(bus.i_pc);
                        end else if (bus.i_op == OP_MRET) begin
                            state           <= RET_STAT;
                            bus.o_csr_ren   <= 1'b1;
                            bus.o_csr_raddr <= CSR_MSTATUS;
                            wen_q           <= 1'b1;
                            bus.o_csr_waddr <= CSR_MSTATUS;
                        end else begin
                            state           <= RD;
                            bus.o_csr_ren   <= 1'b1;
                            bus.o_csr_raddr <= bus.i_csr_addr;
                        end
                    end
                end

                RD: begin
                    state <= WR;
                    old_q <= bus.i_csr_rdata;
                    if (!skip_q) begin
                        wen_q           <= 1'b1;
                        bus.o_csr_waddr <= addr_q;
                        wdata_q         <= rmw_value(kind_q, bus.i_csr_rdata, operand_q);
                    end
                end

                WR: begin
                    state         <= RESP;
                    bus.o_done    <= 1'b1;
                    bus.o_rd_data <= old_q;
                end

                TRAP_EPC: begin
                    state           <= TRAP_CAUSE;
                    wen_q           <= 1'b1;
                    bus.o_csr_waddr <= CSR_MCAUSE;
                    wdata_q         <= DATA_WIDTH'(ECALL_CAUSE);
                end

                TRAP_CAUSE: begin
                    state           <= TRAP_STAT;
                    bus.o_csr_ren   <= 1'b1;
                    bus.o_csr_raddr <= CSR_MSTATUS;
                    wen_q           <= 1'b1;
                    bus.o_csr_waddr <= CSR_MSTATUS;
                end

                TRAP_STAT: begin
                    state           <= TRAP_VEC;
                    bus.o_csr_ren   <= 1'b1;
                    bus.o_csr_raddr <= CSR_MTVEC;
                end

                TRAP_VEC: begin
                    state          <= RESP;
                    bus.o_done     <= 1'b1;
                    bus.o_redirect <= 1'b1;
                    bus.o_nextpc   <= PC_WIDTH'({bus.i_csr_rdata[DATA_WIDTH-1:2], 2'b00});
                end

                RET_STAT: begin
                    state           <= RET_EPC;
                    bus.o_csr_ren   <= 1'b1;
                    bus.o_csr_raddr <= CSR_MEPC;
                end

                RET_EPC: begin
                    state          <= RESP;
                    bus.o_done     <= 1'b1;
                    bus.o_redirect <= 1'b1;
                    bus.o_nextpc   <= PC_WIDTH'(bus.i_csr_rdata);
                end

                RESP: begin
                    state       <= IDLE;
                    bus.o_ready <= 1'b1;
                end

                default: begin
                    state       <= IDLE;
                    bus.o_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_22050710_csr_ctrl.sv
// Bench for the CSR sequencing controller: a CSR file model, a cycle-level
// expectation queue built from the architectural rules, directed and random requests.
module tb_ysyx_22050710_csr_ctrl;
    logic i_clk;
    logic i_rst;
    logic preload;
    logic running;

    int checks;
    int errors;
    int cyc;
    int acc_cyc;
    int done_cnt;
    int last_lat;
    logic [63:0] last_rd;
    logic [63:0] last_redir;
    logic [63:0] last_npc;

    logic [63:0] csr_mem [0:4095];
    logic [63:0] ref_csr [0:4095];

    typedef struct {
        logic        ren;
        logic [11:0] raddr;
        logic        wen;
        logic [11:0] waddr;
        logic [63:0] wdata;
        logic        done;
        logic [63:0] rd;
        logic        redir;
        logic [63:0] npc;
    } exp_t;

    exp_t exp_q [$];

    ysyx_22050710_csr_ctrl_if #(.ADDR_WIDTH(12), .DATA_WIDTH(64)) bus ();

    ysyx_22050710_csr_ctrl #(
        .ADDR_WIDTH (12),
        .DATA_WIDTH (64),
        .ECALL_CAUSE(11)
    ) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .bus  (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // CSR file: combinational read, write commits on the clock edge
    assign bus.i_csr_rdata = bus.o_csr_ren ? csr_mem[bus.o_csr_raddr] : 64'd0;

    always @(posedge i_clk) begin
        if (preload) begin
            for (int i = 0; i < 4096; i++) csr_mem[i] <= 64'd0;
            csr_mem[12'h300] <= 64'h0000_000a_0000_1800;
        end else if (bus.o_csr_wen) begin
            csr_mem[bus.o_csr_waddr] <= bus.o_csr_wdata;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic exp_t idle_rec();
        exp_t r;
        r.ren = 1'b0; r.raddr = 12'd0; r.wen = 1'b0; r.waddr = 12'd0; r.wdata = 64'd0;
        r.done = 1'b0; r.rd = 64'd0; r.redir = 1'b0; r.npc = 64'd0;
        return r;
    endfunction

    // Turn an accepted request into the per-cycle port activity it must produce.
    task automatic build_seq();
        exp_t r;
        logic [2:0]  op;
        logic [11:0] a;
        logic [63:0] s, old, opnd, nv;
        logic        skip;
        op = bus.i_op;
        if (op == 3'b100) begin
            r = idle_rec(); r.wen = 1'b1; r.waddr = 12'h341; r.wdata = bus.i_pc; exp_q.push_back(r);
            r = idle_rec(); r.wen = 1'b1; r.waddr = 12'h342; r.wdata = 64'd11; exp_q.push_back(r);
            s = ref_csr[12'h300];
            r = idle_rec(); r.ren = 1'b1; r.raddr = 12'h300; r.wen = 1'b1; r.waddr = 12'h300;
            r.wdata = (s & ~64'h1888) | (((s >> 3) & 64'd1) << 7) | 64'h1800;
            exp_q.push_back(r);
            r = idle_rec(); r.ren = 1'b1; r.raddr = 12'h305; exp_q.push_back(r);
            r = idle_rec(); r.done = 1'b1; r.redir = 1'b1; r.npc = ref_csr[12'h305] & ~64'd3;
            exp_q.push_back(r);
        end else if (op == 3'b000) begin
            s = ref_csr[12'h300];
            r = idle_rec(); r.ren = 1'b1; r.raddr = 12'h300; r.wen = 1'b1; r.waddr = 12'h300;
            r.wdata = (s & ~64'h1888) | (((s >> 7) & 64'd1) << 3) | 64'h80 | 64'h1800;
            exp_q.push_back(r);
            r = idle_rec(); r.ren = 1'b1; r.raddr = 12'h341; exp_q.push_back(r);
            r = idle_rec(); r.done = 1'b1; r.redir = 1'b1; r.npc = ref_csr[12'h341];
            exp_q.push_back(r);
        end else begin
            a    = bus.i_csr_addr;
            old  = ref_csr[a];
            opnd = (op >= 3'd5) ? 64'(bus.i_uimm) : bus.i_rs1_data;
            skip = (op == 3'd2 || op == 3'd3 || op == 3'd6 || op == 3'd7) && (bus.i_uimm == 5'd0);
            if (op == 3'd1 || op == 3'd5)      nv = opnd;
            else if (op == 3'd2 || op == 3'd6) nv = old | opnd;
            else                               nv = old & ~opnd;
            r = idle_rec(); r.ren = 1'b1; r.raddr = a; exp_q.push_back(r);
            r = idle_rec();
            if (!skip) begin r.wen = 1'b1; r.waddr = a; r.wdata = nv; end
            exp_q.push_back(r);
            r = idle_rec(); r.done = 1'b1; r.rd = old; exp_q.push_back(r);
        end
    endtask

    // Single compare process: every cycle, just before the active edge.
    task automatic monitor();
        exp_t e;
        logic busy;
        for (int i = 0; i < 4096; i++) ref_csr[i] = 64'd0;
        ref_csr[12'h300] = 64'h0000_000a_0000_1800;
        while (running) begin
            @(negedge i_clk);
            #3;
            cyc++;
            busy = (exp_q.size() != 0);
            e = busy ? exp_q[0] : idle_rec();
            if (i_rst) begin
                chk("wen_in_reset", 64'(bus.o_csr_wen), 64'd0);
                exp_q.delete();
            end else begin
                chk("ready",    64'(bus.o_ready),     64'(!busy));
                chk("ren",      64'(bus.o_csr_ren),   64'(e.ren));
                chk("raddr",    64'(bus.o_csr_raddr), 64'(e.raddr));
                chk("wen",      64'(bus.o_csr_wen),   64'(e.wen));
                chk("waddr",    64'(bus.o_csr_waddr), 64'(e.waddr));
                chk("wdata",    bus.o_csr_wdata,      e.wdata);
                chk("done",     64'(bus.o_done),      64'(e.done));
                chk("rd_data",  bus.o_rd_data,        e.rd);
                chk("redirect", 64'(bus.o_redirect),  64'(e.redir));
                chk("nextpc",   bus.o_nextpc,         e.npc);
                if (bus.o_done) begin
                    done_cnt++;
                    last_lat   = cyc - acc_cyc;
                    last_rd    = bus.o_rd_data;
                    last_redir = 64'(bus.o_redirect);
                    last_npc   = bus.o_nextpc;
                end
                if (busy) begin
                    exp_q.delete(0);
                    if (e.wen) ref_csr[e.waddr] = e.wdata;
                end else if (bus.i_valid) begin
                    acc_cyc = cyc;
                    build_seq();
                end
            end
        end
    endtask

    task automatic noise();
        bus.i_op       = 3'($urandom_range(0, 7));
        bus.i_csr_addr = 12'($urandom);
        bus.i_rs1_data = {$urandom, $urandom};
        bus.i_uimm     = 5'($urandom);
        bus.i_pc       = {$urandom, $urandom};
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.o_ready !== 1'b1 && n < 40) begin
            @(negedge i_clk);
            n++;
        end
        if (n >= 40) chk("idle_timeout", 64'(bus.o_ready), 64'd1);
    endtask

    task automatic drive(input logic [2:0] op, input logic [11:0] a, input logic [63:0] rs1,
                         input logic [4:0] uimm, input logic [63:0] pc);
        bus.i_op = op; bus.i_csr_addr = a; bus.i_rs1_data = rs1; bus.i_uimm = uimm; bus.i_pc = pc;
        bus.i_valid = 1'b1;
    endtask

    task automatic do_req(input logic [2:0] op, input logic [11:0] a, input logic [63:0] rs1,
                          input logic [4:0] uimm, input logic [63:0] pc);
        wait_idle();
        drive(op, a, rs1, uimm, pc);
        @(negedge i_clk);
        bus.i_valid = 1'b0;
        noise();
    endtask

    task automatic stimulus();
        int dc;
        logic [2:0]  op;
        logic [11:0] a;
        logic [4:0]  u;
        bus.i_valid = 1'b0;
        noise();
        preload = 1'b1;
        i_rst   = 1'b1;
        repeat (3) @(negedge i_clk);
        preload = 1'b0;
        i_rst   = 1'b0;
        @(negedge i_clk);
        chk("reset_ready",  64'(bus.o_ready),  64'd1);
        chk("reset_done",   64'(bus.o_done),   64'd0);
        chk("reset_nextpc", bus.o_nextpc,      64'd0);

        do_req(3'b001, 12'h305, 64'h8000_0100, 5'd1, 64'd0); wait_idle();
        chk("rw_latency", 64'(last_lat), 64'd3);
        chk("rw_rd",      last_rd, 64'd0);
        chk("rw_mtvec",   csr_mem[12'h305], 64'h8000_0100);

        do_req(3'b010, 12'h300, 64'h8, 5'd5, 64'd0); wait_idle();
        chk("rs_rd",      last_rd, 64'h0000_000a_0000_1800);
        chk("rs_mstatus", csr_mem[12'h300], 64'h0000_000a_0000_1808);

        do_req(3'b010, 12'h300, 64'h8, 5'd0, 64'd0); wait_idle();
        chk("rs_x0_rd",      last_rd, 64'h0000_000a_0000_1808);
        chk("rs_x0_mstatus", csr_mem[12'h300], 64'h0000_000a_0000_1808);

        do_req(3'b111, 12'h300, 64'hffff, 5'd8, 64'd0); wait_idle();
        chk("rci_mstatus", csr_mem[12'h300], 64'h0000_000a_0000_1800);

        do_req(3'b001, 12'h305, 64'h8000_0101, 5'd1, 64'd0);
        do_req(3'b110, 12'h300, 64'd0, 5'd8, 64'd0); wait_idle();
        chk("rsi_mstatus", csr_mem[12'h300], 64'h0000_000a_0000_1808);

        do_req(3'b100, 12'h123, 64'd0, 5'd0, 64'h8000_0040); wait_idle();
        chk("ecall_mepc",    csr_mem[12'h341], 64'h8000_0040);
        chk("ecall_mcause",  csr_mem[12'h342], 64'd11);
        chk("ecall_mstatus", csr_mem[12'h300], 64'h0000_000a_0000_1880);
        chk("ecall_model",   ref_csr[12'h300], 64'h0000_000a_0000_1880);
        chk("ecall_latency", 64'(last_lat), 64'd5);
        chk("ecall_redir",   last_redir, 64'd1);
        chk("ecall_nextpc",  last_npc, 64'h8000_0100);
        chk("ecall_rd",      last_rd, 64'd0);

        do_req(3'b001, 12'h341, 64'h8000_0044, 5'd1, 64'd0);
        do_req(3'b000, 12'h000, 64'd0, 5'd0, 64'd0); wait_idle();
        chk("mret_mstatus", csr_mem[12'h300], 64'h0000_000a_0000_1888);
        chk("mret_latency", 64'(last_lat), 64'd3);
        chk("mret_redir",   last_redir, 64'd1);
        chk("mret_nextpc",  last_npc, 64'h8000_0044);

        // Reset while the ECALL is writing MCAUSE; valid stays high through the busy cycle.
        do_req(3'b001, 12'h342, 64'h55, 5'd1, 64'd0); wait_idle();
        dc = done_cnt;
        drive(3'b100, 12'h000, 64'd0, 5'd0, 64'h1234);
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b1;
        bus.i_valid = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b0;
        chk("rst_ready",   64'(bus.o_ready), 64'd1);
        chk("rst_mepc",    csr_mem[12'h341], 64'h1234);
        chk("rst_mcause",  csr_mem[12'h342], 64'h55);
        chk("rst_mstatus", csr_mem[12'h300], 64'h0000_000a_0000_1888);
        chk("rst_no_done", 64'(done_cnt - dc), 64'd0);

        // Valid held for 8 cycles: accepted only at T and T+4.
        wait_idle();
        dc = done_cnt;
        drive(3'b010, 12'h340, 64'h1, 5'd1, 64'd0);
        repeat (8) @(negedge i_clk);
        bus.i_valid = 1'b0;
        wait_idle();
        chk("hold_dones",    64'(done_cnt - dc), 64'd2);
        chk("hold_mscratch", csr_mem[12'h340], 64'h1);

        for (int k = 0; k < 250; k++) begin
            op = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 4))
                0: a = 12'h300;
                1: a = 12'h305;
                2: a = 12'h340;
                3: a = 12'h341;
                default: a = 12'h342;
            endcase
            u = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            do_req(op, a, {$urandom, $urandom}, u, {$urandom, $urandom});
            if ($urandom_range(0, 11) == 0) begin
                repeat ($urandom_range(0, 4)) @(negedge i_clk);
                i_rst = 1'b1;
                @(negedge i_clk);
                i_rst = 1'b0;
            end
            repeat ($urandom_range(0, 2)) @(negedge i_clk);
        end
        wait_idle();
        repeat (2) @(negedge i_clk);
        running = 1'b0;
    endtask

    initial begin
        running  = 1'b1;
        checks   = 0;
        errors   = 0;
        cyc      = 0;
        acc_cyc  = 0;
        done_cnt = 0;
        last_lat = 0;
        last_rd  = 64'd0;
        last_redir = 64'd0;
        last_npc = 64'd0;
        i_rst    = 1'b1;
        preload  = 1'b1;
        fork
            monitor();
            stimulus();
        join
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ysyx_22050710_csr_ctrl.md
Name: ysyx_22050710_csr_ctrl

Overview:
- Sequencing controller that drives the CSR register file's single read port and single write port on behalf of the execute stage.
- Executes the Zicsr read-modify-write ops (CSRRW/S/C and their immediate forms), ECALL trap entry, and MRET trap return as multi-cycle sequences.
- Returns the old CSR value for rd, and a PC redirect for ECALL/MRET.
- Sits between the decoder/EXU and the CSR file; it is the initiator for every CSR file access.

Parameters:
- ADDR_WIDTH, 12, CSR address width.
- DATA_WIDTH, 64, CSR/GPR data width.
- ECALL_CAUSE, 11, mcause value written on ECALL from M-mode.

Ports:
- i_clk  in  1  clock; all state changes on posedge.
- i_rst  in  1  synchronous active-high reset.
- i_valid  in  1  request valid.
- o_ready  out  1  controller idle; a request is accepted when i_valid & o_ready.
- i_op  in  3  000 MRET, 001 CSRRW, 010 CSRRS, 011 CSRRC, 100 ECALL, 101 CSRRWI, 110 CSRRSI, 111 CSRRCI.
- i_csr_addr  in  ADDR_WIDTH  target CSR (ignored for ECALL/MRET).
- i_rs1_data  in  DATA_WIDTH  rs1 value (register forms).
- i_uimm  in  5  zimm / rs1 index; zero-extended as operand for immediate forms; register forms use i_uimm==0 to detect rs1=x0.
- i_pc  in  64  PC of the request (MEPC value for ECALL).
- o_csr_raddr  out  ADDR_WIDTH  CSR file read address.
- o_csr_ren  out  1  CSR file read enable.
- i_csr_rdata  in  DATA_WIDTH  CSR file read data; combinational from raddr/ren, same cycle.
- o_csr_waddr  out  ADDR_WIDTH  CSR file write address.
- o_csr_wdata  out  DATA_WIDTH  CSR file write data.
- o_csr_wen  out  1  CSR file write enable; the file commits the write at the same posedge.
- o_done  out  1  one-cycle completion pulse.
- o_rd_data  out  DATA_WIDTH  old CSR value; valid with o_done, 0 for ECALL/MRET.
- o_redirect  out  1  with o_done: PC must be replaced by o_nextpc.
- o_nextpc  out  64  redirect target.

Behaviour:
- Reset: state IDLE. o_ready=1; all other outputs 0; internal latches cleared.
- Reset in any state returns to IDLE on that edge. No further CSR writes are issued; writes already committed are not undone.
- Acceptance (cycle T, IDLE & i_valid):
  - latch op, addr, pc;
  - operand = register forms ? i_rs1_data : zero-extend(i_uimm);
  - skip_wr = (op is RS/RC/RSI/RCI) & (i_uimm==0).
- o_ready=1 only in IDLE, so no request is accepted while busy.
- CSR op sequence:
  - RD (T+1): raddr=addr, ren=1, capture old=i_csr_rdata.
  - WR (T+2): wen=!skip_wr, waddr=addr, wdata = RW: operand; RS: old|operand; RC: old&~operand.
  - RESP (T+3): o_done=1, o_rd_data=old, o_redirect=0.
  - CSRRW is always read, even when rd=x0.
- ECALL sequence (MSTATUS=0x300, MTVEC=0x305, MEPC=0x341, MCAUSE=0x342):
  - T+1 EPC: write MEPC <= latched pc.
  - T+2 CAUSE: write MCAUSE <= ECALL_CAUSE.
  - T+3 STAT: read MSTATUS and write back with bit7 (MPIE) <= bit3 (MIE), bit3 <= 0, bits12:11 (MPP) <= 2'b11; other bits unchanged.
  - T+4 VEC: read MTVEC, nextpc = {mtvec[63:2],2'b00} (direct mode only).
  - T+5 RESP: o_done=1, o_redirect=1, o_nextpc=nextpc, o_rd_data=0.
- MRET sequence:
  - T+1 STAT: read MSTATUS and write back with bit3 <= bit7, bit7 <= 1, bits12:11 <= 2'b11.
  - T+2 EPC: read MEPC, nextpc = mepc.
  - T+3 RESP: o_done=1, o_redirect=1.
- Port and output activity:
  - At most one read and one write per cycle.
  - o_csr_ren and o_csr_wen are 0 in IDLE and RESP.
  - Addresses and data are don't-care when the enables are low; drive 0.
- Back-to-back requests:
  - RESP returns to IDLE; the next request can be accepted at RESP+1.
  - A read in the cycle after a write to the same CSR returns the new value.
- o_done, o_redirect, o_nextpc and o_rd_data are registered. They are held 0 outside RESP.
- FSM states: IDLE, RD, WR, TRAP_EPC, TRAP_CAUSE, TRAP_STAT, TRAP_VEC, RET_STAT, RET_EPC, RESP.
- All arithmetic is bitwise at DATA_WIDTH; no carries.

Test Plan:
- CSRRW 0x305, rs1=0x8000_0100, MTVEC initially 0 -> done at T+3 with rd_data=0; a single write of 0x80000100 to 0x305 at T+2.
- CSRRS 0x300 with rs1 data 0x8 and i_uimm=5, MSTATUS=0xa00001800 -> rd_data=0xa00001800; written value 0xa00001808. Repeat with i_uimm=0 -> no wen.
- CSRRCI 0x300, uimm=0x8, MSTATUS=0xa00001808 -> writes 0xa00001800.
- ECALL, pc=0x80000040, MTVEC=0x80000101, MSTATUS=0xa00001808 -> MEPC=0x80000040, MCAUSE=11, MSTATUS=0xa00001880; done at T+5 with redirect=1, nextpc=0x80000100.
- MRET after the above (MEPC=0x80000044) -> MSTATUS=0xa00001888, done at T+3 with redirect=1, nextpc=0x80000044.
- i_rst asserted during TRAP_CAUSE of an ECALL -> next cycle IDLE, o_ready=1, MEPC written, MCAUSE and MSTATUS untouched, no o_done; i_valid held high while busy is not accepted until IDLE.
